// File: rtl/urv_rf_access_ctrl_pkg.sv
// Shared definitions for the uRV register-file access sequencer:
// FSM state encoding, register index constants, scrub pointer stepping.
package urv_rf_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RD_SLOT = 3'd1,
      ST_RD_DATA = 3'd2,
      ST_WR_SLOT = 3'd3,
      ST_ACK     = 3'd4,
      ST_SC_SLOT = 3'd5,
      ST_SC_DATA = 3'd6
   } rf_ctrl_state_e;

   localparam logic [4:0] RF_X0          = 5'd0;
   localparam logic [4:0] RF_XLAST       = 5'd31;
   localparam logic [4:0] RF_SCRUB_FIRST = 5'd1;

   // Scrub walks x1..x31 and skips x0, which has no storage.
   function automatic logic [4:0] scrub_next(input logic [4:0] p);
      return (p == RF_XLAST) ? RF_SCRUB_FIRST : p + 5'd1;
   endfunction

endpackage

// File: rtl/urv_rf_access_ctrl_if.sv
// Debug-host request/ack bus of the register-file access sequencer.
// Signal names are seen from the sequencer side (_i driven by the host).
interface urv_rf_access_ctrl_if;
   logic        dbg_req_i;
   logic        dbg_we_i;
   logic [4:0]  dbg_addr_i;
   logic [31:0] dbg_wdata_i;
   logic        dbg_ack_o;
   logic [31:0] dbg_rdata_o;
   logic        dbg_err_o;

   modport master (output dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
                   input  dbg_ack_o, dbg_rdata_o, dbg_err_o);
   modport slave  (input  dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
                   output dbg_ack_o, dbg_rdata_o, dbg_err_o);
endinterface

// File: rtl/urv_rf_slot_timer.sv
// Clear/increment counter that flags the cycle in which the LIMIT-th
// increment happens. Used for the slot-wait timeout and the scrub gap.
// LIMIT must be at least 1 and fit in W bits.
module urv_rf_slot_timer #(
   parameter int W     = 8,
   parameter int LIMIT = 255
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic clr_i,
   input  logic inc_i,
   output logic expire_o
);
   localparam logic [W-1:0] LAST = W'(LIMIT - 1);

   logic [W-1:0] cnt_q, cnt_d;

   // Clear wins over increment.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)      cnt_d = '0;
      else if (inc_i) cnt_d = cnt_q + 1'b1;
   end

   // Counter state.
   always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i) cnt_q <= '0;
      else          cnt_q <= cnt_d;

   assign expire_o = inc_i && !clr_i && (cnt_q == LAST);
endmodule

// File: rtl/urv_rf_access_ctrl.sv
// Inserts debug-host reads/writes of x0..x31 into regfile port cycles the
// pipeline leaves free. Optional background ECC scrubber of x1..x31 is
// enabled with the URV_RF_SCRUB_EN macro.
module urv_rf_access_ctrl
   import urv_rf_ctrl_pkg::*;
#(
   parameter int g_timeout   = 255,
   parameter int g_scrub_gap = 1024
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   urv_rf_access_ctrl_if.slave dbg,
   input  logic        rf_rd_slot_i,
   output logic        rf_rd_en_o,
   output logic [4:0]  rf_rd_addr_o,
   input  logic [31:0] rf_rd_data_i,
   input  logic        rf_rd_ecc_err_i,
   input  logic        w_rd_store_i,
   output logic        rf_wr_en_o,
   output logic [4:0]  rf_wr_addr_o,
   output logic [31:0] rf_wr_data_o,
   output logic [15:0] scrub_err_cnt_o,
   output logic        scrub_irq_o
);
   rf_ctrl_state_e state_q;
   logic [4:0]     addr_q;
   logic [31:0]    wdata_q;
   logic           ack_q;
   logic [31:0]    rdata_q;
   logic           err_q;
   logic           wait_cyc;
   logic           to_expire;

   // A slot state that did not get its port this cycle burns timeout budget.
   always_comb begin
      wait_cyc = 1'b0;
      if ((state_q == ST_RD_SLOT || state_q == ST_SC_SLOT) && !rf_rd_slot_i) wait_cyc = 1'b1;
      if (state_q == ST_WR_SLOT && w_rd_store_i)                             wait_cyc = 1'b1;
   end

   urv_rf_slot_timer #(.W(8), .LIMIT(g_timeout)) u_timeout (
      .clk_i    (clk_i),
      .rst_n_i  (rst_n_i),
      .clr_i    (state_q == ST_IDLE),
      .inc_i    (wait_cyc),
      .expire_o (to_expire)
   );

`ifdef URV_RF_SCRUB_EN
   localparam int GAP_W = $clog2(g_scrub_gap) + 1;

   logic [4:0]  ptr_q;
   logic [15:0] err_cnt_q;
   logic        irq_q;
   logic        gap_expire;

   urv_rf_slot_timer #(.W(GAP_W), .LIMIT(g_scrub_gap)) u_gap (
      .clk_i    (clk_i),
      .rst_n_i  (rst_n_i),
      .clr_i    (state_q != ST_IDLE || dbg.dbg_req_i),
      .inc_i    (state_q == ST_IDLE && !dbg.dbg_req_i),
      .expire_o (gap_expire)
   );

   // Scrub pointer, saturating error count and per-error interrupt pulse.
   always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i) begin
         ptr_q     <= RF_SCRUB_FIRST;
         err_cnt_q <= '0;
         irq_q     <= 1'b0;
      end else begin
         irq_q <= (state_q == ST_SC_DATA) && rf_rd_ecc_err_i;
         if (state_q == ST_SC_DATA && rf_rd_ecc_err_i && err_cnt_q != 16'hFFFF)
            err_cnt_q <= err_cnt_q + 16'd1;
         if (state_q == ST_SC_DATA || (state_q == ST_SC_SLOT && to_expire))
            ptr_q <= scrub_next(ptr_q);
      end

   assign rf_rd_addr_o    = (state_q == ST_SC_SLOT) ? ptr_q : addr_q;
   assign scrub_err_cnt_o = err_cnt_q;
   assign scrub_irq_o     = irq_q;
`else
   assign rf_rd_addr_o    = addr_q;
   assign scrub_err_cnt_o = '0;
   assign scrub_irq_o     = 1'b0;
`endif

   // Access sequencer; ack/rdata/err are registered and change only on entry to ACK.
   always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         ack_q   <= 1'b0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         ack_q <= 1'b0;
         case (state_q)
            ST_IDLE:
               if (dbg.dbg_req_i) begin
                  addr_q  <= dbg.dbg_addr_i;
                  wdata_q <= dbg.dbg_wdata_i;
                  if (dbg.dbg_addr_i == RF_X0) begin
                     // x0 is hardwired: no port access, reads return 0.
                     state_q <= ST_ACK;
                     ack_q   <= 1'b1;
                     rdata_q <= '0;
                     err_q   <= 1'b0;
                  end else begin
                     state_q <= dbg.dbg_we_i ? ST_WR_SLOT : ST_RD_SLOT;
                  end
               end
`ifdef URV_RF_SCRUB_EN
               else if (gap_expire) state_q <= ST_SC_SLOT;
`endif
            ST_RD_SLOT:
               if (rf_rd_slot_i) state_q <= ST_RD_DATA;
               else if (to_expire) begin
                  state_q <= ST_ACK;
                  ack_q   <= 1'b1;
                  rdata_q <= '0;
                  err_q   <= 1'b1;
               end
            ST_RD_DATA: begin
               state_q <= ST_ACK;
               ack_q   <= 1'b1;
               rdata_q <= rf_rd_data_i;
               err_q   <= rf_rd_ecc_err_i;
            end
            ST_WR_SLOT:
               if (!w_rd_store_i || to_expire) begin
                  state_q <= ST_ACK;
                  ack_q   <= 1'b1;
                  rdata_q <= '0;
                  err_q   <= w_rd_store_i;
               end
            ST_ACK: state_q <= ST_IDLE;
`ifdef URV_RF_SCRUB_EN
            ST_SC_SLOT:
               if (rf_rd_slot_i)   state_q <= ST_SC_DATA;
               else if (to_expire) state_q <= ST_IDLE;
            ST_SC_DATA: state_q <= ST_IDLE;
`endif
            default: state_q <= ST_IDLE;
         endcase
      end

   // Port strobes follow the pipeline's free-slot signals in the same cycle.
   assign rf_rd_en_o   = (state_q == ST_RD_SLOT || state_q == ST_SC_SLOT) && rf_rd_slot_i;
   assign rf_wr_en_o   = (state_q == ST_WR_SLOT) && !w_rd_store_i;
   assign rf_wr_addr_o = addr_q;
   assign rf_wr_data_o = wdata_q;

   assign dbg.dbg_ack_o   = ack_q;
   assign dbg.dbg_rdata_o = rdata_q;
   assign dbg.dbg_err_o   = err_q;
endmodule
